bus_master_mux: RTL and testbench

//   Downstream companion of bus_arbiter. Takes m0_grnt/m1_grnt, muxes the granted

---
 rtl/bus_master_mux.sv | 176 +++++++++++++++++
 tb/tb_bus_master_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_master_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_mux
//  Description : Routes the granted master's request (m0 = data port,
//                m1 = instruction port) onto a single slave bus, tracks one
//                outstanding transaction with an optional ack timeout, and
//                returns read data and a one-cycle ready pulse to its owner.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_master_mux #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_grnt,
    input  logic                m1_grnt,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_be,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                busy,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;
    // Counter only has to hold TIMEOUT-1: the abort fires on the cycle it
    // would have reached TIMEOUT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;      // 0 = m0, 1 = m1
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q,    be_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                w_timeout;

    // Timeout detection is compiled out entirely when TIMEOUT is zero
    if (TIMEOUT != 0) begin : g_timeout
        assign w_timeout = (cnt_q == c_CNT_LAST);
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Next-state logic: start selection, ack/timeout handling, completion
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            S_IDLE: begin
                // m0 has priority if the arbiter ever asserts both grants
                if (m0_grnt && m0_req) begin
                    owner_d = 1'b0;
                    we_d    = m0_we;
                    addr_d  = m0_addr;
                    wdata_d = m0_wdata;
                    be_d    = m0_be;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end else if (m1_grnt && m1_req) begin
                    owner_d = 1'b1;
                    we_d    = m1_we;
                    addr_d  = m1_addr;
                    wdata_d = m1_wdata;
                    be_d    = m1_be;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // An ack arriving on the timeout cycle still completes normally
                if (s_ack) begin
                    if (!we_q) begin
                        if (owner_q) m1_rdata_d = s_rdata;
                        else         m0_rdata_d = s_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (w_timeout) begin
                    if (owner_q) m1_rdata_d = '1;
                    else         m0_rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign s_req    = (state_q == S_BUS);
    assign s_we     = s_req & we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_be     = be_q;
    assign busy     = (state_q != S_IDLE);
    assign err      = err_q;
    assign m0_ready = (state_q == S_DONE) & ~owner_q;
    assign m1_ready = (state_q == S_DONE) &  owner_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_master_mux
//  Description : Directed self-checking bench for bus_master_mux. A second
//                instance with a short timeout shares the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_master_mux;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'hA5A5_A5A5;
    localparam logic [31:0] W1 = 32'h1234_5678;
    localparam logic [3:0]  B0 = 4'hF;
    localparam logic [3:0]  B1 = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_grnt, m1_grnt, m0_req, m1_req, m0_we, m1_we, s_ack;
    logic [31:0] s_rdata;

    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ready, m1_ready, s_req, s_we, busy, err;
    logic [3:0]  s_be;

    logic [31:0] to_m0_rdata, to_m1_rdata, to_s_addr, to_s_wdata;
    logic        to_m0_ready, to_m1_ready, to_s_req, to_s_we, to_busy, to_err;
    logic [3:0]  to_s_be;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    bus_master_mux #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .m0_grnt(m0_grnt), .m1_grnt(m1_grnt),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(A0), .m0_wdata(W0), .m0_be(B0),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(A1), .m1_wdata(W1), .m1_be(B1),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_ack(s_ack), .s_rdata(s_rdata), .busy(busy), .err(err)
    );

    bus_master_mux #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .m0_grnt(m0_grnt), .m1_grnt(m1_grnt),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(A0), .m0_wdata(W0), .m0_be(B0),
        .m0_rdata(to_m0_rdata), .m0_ready(to_m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(A1), .m1_wdata(W1), .m1_be(B1),
        .m1_rdata(to_m1_rdata), .m1_ready(to_m1_ready),
        .s_req(to_s_req), .s_we(to_s_we), .s_addr(to_s_addr), .s_wdata(to_s_wdata),
        .s_be(to_s_be), .s_ack(s_ack), .s_rdata(s_rdata), .busy(to_busy), .err(to_err)
    );

    // One row = inputs held for one cycle, then outputs expected after the edge.
    // flags = {s_req, s_we, busy, m0_ready, m1_ready, err}
    typedef struct {
        logic        rst, g0, g1, r0, r1, we0, we1, ack;
        logic [31:0] srd;
        logic [5:0]  flags;
        logic [31:0] saddr, swdata;
        logic [3:0]  sbe;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_v, g0, g1, r0, r1, we0, we1, ack,
                       input logic [31:0] srd, input logic [5:0] flags,
                       input logic [31:0] saddr, swdata, input logic [3:0] sbe,
                       input logic [31:0] rd0, rd1);
        vec_t v;
        v.rst = rst_v; v.g0 = g0; v.g1 = g1; v.r0 = r0; v.r1 = r1;
        v.we0 = we0; v.we1 = we1; v.ack = ack; v.srd = srd; v.flags = flags;
        v.saddr = saddr; v.swdata = swdata; v.sbe = sbe; v.rd0 = rd0; v.rd1 = rd1;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_grnt = 0; m1_grnt = 0; m0_req = 0; m1_req = 0;
        m0_we = 0; m1_we = 0; s_ack = 0; s_rdata = '0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_inputs();

        //   rst g0 g1 r0 r1 we0 we1 ack srd            flags      saddr swdata sbe rd0           rd1
        add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 32'h0, 32'h0, 4'h0, 32'h0,         32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'b000000, 32'h0, 32'h0, 4'h0, 32'h0,         32'h0);
        // m0 read, ack on first BUS cycle; req still held in DONE must not restart
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0,         6'b101000, A0, W0, B0, 32'h0,         32'h0);
        add(0, 1, 0, 1, 0, 0, 0, 1, 32'hCAFEF00D,  6'b001100, A0, W0, B0, 32'hCAFEF00D,  32'h0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0,         6'b000000, A0, W0, B0, 32'hCAFEF00D,  32'h0);
        // stray ack in IDLE is ignored
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,  6'b000000, A0, W0, B0, 32'hCAFEF00D,  32'h0);
        // m1 write, ack on 5th BUS cycle; m1_rdata untouched
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b111000, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b111000, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b111000, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b111000, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b111000, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 1, 32'h55555555,  6'b001010, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 32'h0,         6'b000000, A1, W1, B1, 32'hCAFEF00D,  32'h0);
        // grant flips to m1 mid-transfer of m0
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0,         6'b101000, A0, W0, B0, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 1, 1, 0, 1, 0, 32'h0,         6'b101000, A0, W0, B0, 32'hCAFEF00D,  32'h0);
        add(0, 0, 1, 1, 1, 0, 1, 1, 32'h0BADF00D,  6'b001100, A0, W0, B0, 32'h0BADF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b000000, A0, W0, B0, 32'h0BADF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 32'h0,         6'b111000, A1, W1, B1, 32'h0BADF00D,  32'h0);
        add(0, 0, 1, 0, 1, 0, 1, 1, 32'h0,         6'b001010, A1, W1, B1, 32'h0BADF00D,  32'h0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 32'h0,         6'b000000, A1, W1, B1, 32'h0BADF00D,  32'h0);
        // both grants high: m0 first, m1 read three cycles later
        add(0, 1, 1, 1, 1, 0, 0, 0, 32'h0,         6'b101000, A0, W0, B0, 32'h0BADF00D,  32'h0);
        add(0, 1, 1, 1, 1, 0, 0, 1, 32'h11111111,  6'b001100, A0, W0, B0, 32'h11111111,  32'h0);
        add(0, 1, 1, 0, 1, 0, 0, 0, 32'h0,         6'b000000, A0, W0, B0, 32'h11111111,  32'h0);
        add(0, 1, 1, 0, 1, 0, 0, 0, 32'h0,         6'b101000, A1, W1, B1, 32'h11111111,  32'h0);
        add(0, 1, 1, 0, 1, 0, 0, 1, 32'h22222222,  6'b001010, A1, W1, B1, 32'h11111111,  32'h22222222);
        add(0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         6'b000000, A1, W1, B1, 32'h11111111,  32'h22222222);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; m0_grnt = tbl[i].g0; m1_grnt = tbl[i].g1;
            m0_req = tbl[i].r0; m1_req = tbl[i].r1; m0_we = tbl[i].we0;
            m1_we = tbl[i].we1; s_ack = tbl[i].ack; s_rdata = tbl[i].srd;
            step();
            chk($sformatf("row%0d", i),
                160'({s_req, s_we, busy, m0_ready, m1_ready, err, s_addr, s_wdata, s_be, m0_rdata, m1_rdata}),
                160'({tbl[i].flags, tbl[i].saddr, tbl[i].swdata, tbl[i].sbe, tbl[i].rd0, tbl[i].rd1}));
        end

        // Timeout abort on the TIMEOUT=4 instance
        idle_inputs(); rst = 1; step(); rst = 0;
        m0_grnt = 1; m0_req = 1; step();
        chk("to_bus_entry", 160'({to_s_we, to_s_addr, to_s_wdata, to_s_be, to_busy}),
            160'({1'b0, A0, W0, B0, 1'b1}));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!to_s_req) break;
            n++;
            step();
        end
        chk("to_sreq_cycles", 160'(n), 160'd4);
        chk("to_done", 160'({to_m0_ready, to_m1_ready, to_err, to_m0_rdata, to_m1_rdata}),
            160'({1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0}));
        m0_req = 0; step();
        chk("to_err_hold", 160'({to_err, to_m0_ready, to_busy}), 160'(3'b100));
        // ack arriving on the timeout cycle wins and clears err
        m0_req = 1; step();
        step(); step(); step();
        s_ack = 1; s_rdata = 32'h600DF00D; step();
        chk("to_ack_wins", 160'({to_m0_ready, to_err, to_m0_rdata}),
            160'({1'b1, 1'b0, 32'h600DF00D}));
        s_ack = 0; m0_req = 0; step();
        chk("to_back_idle", 160'({to_busy, to_m0_ready, to_err}), 160'(3'b000));

        // Reset during the second BUS cycle abandons the transfer
        idle_inputs(); rst = 1; step(); rst = 0;
        m0_grnt = 1; m0_req = 1; step();
        chk("rst_bus1", 160'({s_req, busy}), 160'(2'b11));
        step();
        rst = 1; step();
        chk("rst_abort", 160'({s_req, busy, m0_ready, m1_ready}), 160'(4'b0000));
        rst = 0; m0_grnt = 0; m0_req = 0; s_ack = 1; s_rdata = 32'hBBBBBBBB; step();
        chk("rst_late_ack", 160'({busy, m0_ready, err, m0_rdata}), 160'({3'b000, 32'h0}));
        s_ack = 0; step();
        chk("rst_no_ready", 160'({m0_ready, m1_ready, s_req}), 160'(3'b000));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
